// File: rtl/mmu_rr_arbiter.sv
// Round-robin arbiter sharing one 4x4 matrix-multiply unit among NUM_REQ requesters.
// One job in flight at a time; a watchdog turns a hung MMU job into an error response.
module mmu_rr_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*16*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*16*DATA_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [16*DATA_W-1:0]           rsp_m,
    output logic                           rsp_err,
    output logic                           mmu_input_valid,
    output logic [16*DATA_W-1:0]           mmu_a,
    output logic [16*DATA_W-1:0]           mmu_b,
    input  logic                           mmu_sink_ready,
    output logic                           mmu_source_ready,
    input  logic                           mmu_output_valid,
    input  logic [16*DATA_W-1:0]           mmu_m,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned MAT_W = 16 * DATA_W;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;

    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   scan_idx;
    logic               found;
    logic               accept;
    logic [MAT_W-1:0]   sel_a;
    logic [MAT_W-1:0]   sel_b;

    // Pick the first valid requester at or after ptr, wrapping; mux its operands.
    always_comb begin
        winner   = '0;
        scan_idx = '0;
        found    = 1'b0;
        sel_a    = '0;
        sel_b    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!found && req_valid[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == IDX_W'(i)) begin
                sel_a = req_a[i*MAT_W +: MAT_W];
                sel_b = req_b[i*MAT_W +: MAT_W];
            end
        end
    end

    // The accept strobe is combinational so the requester sees it in the winning cycle.
    assign accept    = (state == S_IDLE) && found && mmu_sink_ready && !rst;
    assign req_ready = accept ? (NUM_REQ'(1) << winner) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            ptr              <= '0;
            cnt              <= '0;
            grant_id         <= '0;
            mmu_a            <= '0;
            mmu_b            <= '0;
            mmu_input_valid  <= 1'b0;
            mmu_source_ready <= 1'b0;
            rsp_valid        <= '0;
            rsp_m            <= '0;
            rsp_err          <= 1'b0;
            busy             <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mmu_a           <= sel_a;
                        mmu_b           <= sel_b;
                        grant_id        <= winner;
                        mmu_input_valid <= 1'b1;
                        busy            <= 1'b1;
                        state           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mmu_input_valid  <= 1'b0;
                    mmu_source_ready <= 1'b1;
                    cnt              <= '0;
                    state            <= S_WAIT;
                end
                S_WAIT: begin
                    // A result arriving on the final watchdog cycle still counts as a result.
                    if (mmu_output_valid) begin
                        rsp_m            <= mmu_m;
                        rsp_err          <= 1'b0;
                        mmu_source_ready <= 1'b0;
                        rsp_valid        <= NUM_REQ'(1) << grant_id;
                        state            <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_m            <= '0;
                        rsp_err          <= 1'b1;
                        mmu_source_ready <= 1'b0;
                        rsp_valid        <= NUM_REQ'(1) << grant_id;
                        state            <= S_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready[grant_id]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        ptr       <= IDX_W'((32'(grant_id) + 32'd1) % NUM_REQ);
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_rr_arbiter.sv
// Directed bench for mmu_rr_arbiter: the MMU is a stub driven by each scenario task.
module tb_mmu_rr_arbiter;

    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned TIMEOUT_CYC = 64;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned MAT_W       = 16 * DATA_W;

    typedef logic [15:0][DATA_W-1:0] mat_t;

    logic                         clk;
    logic                         rst;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*MAT_W-1:0]     req_a;
    logic [NUM_REQ*MAT_W-1:0]     req_b;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [NUM_REQ-1:0]           rsp_ready;
    logic [MAT_W-1:0]             rsp_m;
    logic                         rsp_err;
    logic                         mmu_input_valid;
    logic [MAT_W-1:0]             mmu_a;
    logic [MAT_W-1:0]             mmu_b;
    logic                         mmu_sink_ready;
    logic                         mmu_source_ready;
    logic                         mmu_output_valid;
    logic [MAT_W-1:0]             mmu_m;
    logic                         busy;
    logic [IDX_W-1:0]             grant_id;

    int n_vec = 0;
    int n_err = 0;
    int acc_cnt = 0;
    int pulse_cnt = 0;
    int rr_bad = 0;

    mmu_rr_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_a            (req_a),
        .req_b            (req_b),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_m            (rsp_m),
        .rsp_err          (rsp_err),
        .mmu_input_valid  (mmu_input_valid),
        .mmu_a            (mmu_a),
        .mmu_b            (mmu_b),
        .mmu_sink_ready   (mmu_sink_ready),
        .mmu_source_ready (mmu_source_ready),
        .mmu_output_valid (mmu_output_valid),
        .mmu_m            (mmu_m),
        .busy             (busy),
        .grant_id         (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept strobes and start pulses seen at each active edge.
    always @(posedge clk) begin
        if (|req_ready) begin
            acc_cnt++;
            if (!$onehot(req_ready)) rr_bad++;
        end
        if (mmu_input_valid) pulse_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    function automatic mat_t pack16(input int unsigned v[16]);
        mat_t m;
        for (int k = 0; k < 16; k++) m[k] = DATA_W'(v[k]);
        return m;
    endfunction

    function automatic mat_t tag(input int unsigned t);
        mat_t m;
        for (int k = 0; k < 16; k++) m[k] = DATA_W'(t + 32'(k));
        return m;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mmu_input_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called at the ISSUE-cycle negedge; returns at the RESP-cycle negedge.
    task automatic mmu_respond(input mat_t m);
        @(negedge clk);
        mmu_output_valid = 1'b1;
        mmu_m            = m;
        @(negedge clk);
        mmu_output_valid = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        mmu_sink_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        n_vec++;
        if ({busy, mmu_input_valid, mmu_source_ready, rsp_err, rsp_valid, grant_id} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: got busy=%b iv=%b sr=%b err=%b rv=%b gid=%0d expected all 0",
                     busy, mmu_input_valid, mmu_source_ready, rsp_err, rsp_valid, grant_id);
        end
        n_vec++;
        if ({rsp_m, mmu_a, mmu_b} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got rsp_m=%h expected 0", rsp_m);
        end
        req_valid = 4'b0000;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_job();
        int unsigned av[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 5};
        int unsigned bv[16] = '{1, 2, 1, 2, 2, 4, 2, 4, 1, 2, 1, 2, 2, 4, 2, 4};
        int unsigned rv[16] = '{10, 20, 10, 20, 34, 68, 34, 68, 28, 56, 28, 56, 22, 44, 22, 44};
        mat_t a, b, r;
        bit ok;
        a = pack16(av);
        b = pack16(bv);
        r = pack16(rv);
        pulse_cnt = 0;
        rsp_ready = 4'b0000;
        req_a[0 +: MAT_W] = a;
        req_b[0 +: MAT_W] = b;
        req_valid = 4'b0001;
        #1;
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL single_req_ready: got %b expected 0001", req_ready);
        end
        wait_start(ok);
        n_vec++;
        if (!ok || mmu_a !== a || mmu_b !== b || grant_id !== 2'd0) begin
            n_err++;
            $display("FAIL single_issue: got ok=%b gid=%0d a=%h expected ok=1 gid=0 a=%h", ok, grant_id, mmu_a, a);
        end
        req_valid = 4'b0000;
        mmu_respond(r);
        n_vec++;
        if (rsp_valid !== 4'b0001 || rsp_m !== r || rsp_err !== 1'b0) begin
            n_err++;
            $display("FAIL single_rsp: got rv=%b err=%b m=%h expected rv=0001 err=0 m=%h", rsp_valid, rsp_err, rsp_m, r);
        end
        rsp_ready = 4'b1110;
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 4'b0001 || rsp_m !== r) begin
            n_err++;
            $display("FAIL single_rsp_hold: got rv=%b m=%h expected rv=0001 m=%h", rsp_valid, rsp_m, r);
        end
        rsp_ready = 4'b0001;
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0 || pulse_cnt != 1) begin
            n_err++;
            $display("FAIL single_done: got rv=%b busy=%b pulses=%0d expected rv=0000 busy=0 pulses=1", rsp_valid, busy, pulse_cnt);
        end
        rsp_ready = 4'b1111;
    endtask

    task automatic test_round_robin();
        bit ok;
        int unsigned exp;
        logic [3:0] exp_oh;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i*MAT_W +: MAT_W] = tag(32'h100 * 32'(i + 1));
            req_b[i*MAT_W +: MAT_W] = tag(32'h200 * 32'(i + 1));
        end
        acc_cnt = 0;
        pulse_cnt = 0;
        rr_bad = 0;
        rsp_ready = 4'b1111;
        req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            exp = 32'(j) % 4;
            exp_oh = 4'b0001 << exp;
            wait_start(ok);
            n_vec++;
            if (!ok || grant_id !== IDX_W'(exp) || mmu_a !== tag(32'h100 * (exp + 1))) begin
                n_err++;
                $display("FAIL rr_grant_%0d: got ok=%b gid=%0d expected gid=%0d", j, ok, grant_id, exp);
            end
            mmu_respond(tag(32'h1000 * 32'(j + 1)));
            n_vec++;
            if (rsp_valid !== exp_oh || rsp_m !== tag(32'h1000 * 32'(j + 1))) begin
                n_err++;
                $display("FAIL rr_rsp_%0d: got rv=%b m=%h expected rv=%b", j, rsp_valid, rsp_m, exp_oh);
            end
            if (j == 4) req_valid = 4'b0000;
        end
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (acc_cnt != 5 || pulse_cnt != 5 || rr_bad != 0) begin
            n_err++;
            $display("FAIL rr_counts: got accepts=%0d pulses=%0d non_onehot=%0d expected 5 5 0", acc_cnt, pulse_cnt, rr_bad);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        req_valid = 4'b1000;
        wait_start(ok);
        n_vec++;
        if (!ok || grant_id !== 2'd3) begin
            n_err++;
            $display("FAIL wrap_grant3: got ok=%b gid=%0d expected gid=3", ok, grant_id);
        end
        req_valid = 4'b0000;
        mmu_respond(tag(32'h3300));
        req_valid = 4'b0100;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0100 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_req2_ready: got rr=%b busy=%b expected rr=0100 busy=0", req_ready, busy);
        end
        wait_start(ok);
        req_valid = 4'b0000;
        mmu_respond(tag(32'h2200));
        n_vec++;
        if (rsp_valid !== 4'b0100 || rsp_m !== tag(32'h2200)) begin
            n_err++;
            $display("FAIL wrap_rsp2: got rv=%b m=%h expected rv=0100", rsp_valid, rsp_m);
        end
        @(negedge clk);
    endtask

    task automatic test_sink_stall();
        bit ok;
        mmu_sink_ready = 1'b0;
        req_valid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (req_ready !== 4'b0000 || mmu_input_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL stall_cycle_%0d: got rr=%b iv=%b busy=%b expected all 0", i, req_ready, mmu_input_valid, busy);
            end
        end
        mmu_sink_ready = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL stall_release: got %b expected 0001", req_ready);
        end
        wait_start(ok);
        req_valid = 4'b0000;
        n_vec++;
        if (!ok || grant_id !== 2'd0) begin
            n_err++;
            $display("FAIL stall_grant: got ok=%b gid=%0d expected gid=0", ok, grant_id);
        end
        mmu_respond(tag(32'h0500));
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok;
        int wait_n;
        req_valid = 4'b0010;
        wait_start(ok);
        req_valid = 4'b0000;
        n_vec++;
        if (!ok || grant_id !== 2'd1) begin
            n_err++;
            $display("FAIL to_grant: got ok=%b gid=%0d expected gid=1", ok, grant_id);
        end
        wait_n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (|rsp_valid) break;
            if (mmu_source_ready) wait_n++;
        end
        n_vec++;
        if (wait_n != TIMEOUT_CYC) begin
            n_err++;
            $display("FAIL to_wait_cycles: got %0d expected %0d", wait_n, TIMEOUT_CYC);
        end
        n_vec++;
        if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_m !== '0 || mmu_source_ready !== 1'b0) begin
            n_err++;
            $display("FAIL to_rsp: got rv=%b err=%b m=%h sr=%b expected rv=0010 err=1 m=0 sr=0",
                     rsp_valid, rsp_err, rsp_m, mmu_source_ready);
        end
        @(negedge clk);
        req_valid = 4'b0100;
        wait_start(ok);
        req_valid = 4'b0000;
        mmu_respond(tag(32'h7700));
        n_vec++;
        if (rsp_valid !== 4'b0100 || rsp_err !== 1'b0 || rsp_m !== tag(32'h7700)) begin
            n_err++;
            $display("FAIL to_recover: got rv=%b err=%b m=%h expected rv=0100 err=0", rsp_valid, rsp_err, rsp_m);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        req_valid = 4'b1000;
        wait_start(ok);
        req_valid = 4'b0000;
        @(negedge clk);
        n_vec++;
        if (mmu_source_ready !== 1'b1 || grant_id !== 2'd3) begin
            n_err++;
            $display("FAIL mid_wait: got sr=%b gid=%0d expected sr=1 gid=3", mmu_source_ready, grant_id);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || mmu_source_ready !== 1'b0 || rsp_m !== '0 || mmu_a !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got busy=%b gid=%0d sr=%b m=%h expected all 0", busy, grant_id, mmu_source_ready, rsp_m);
        end
        mmu_output_valid = 1'b1;
        mmu_m = tag(32'h9900);
        @(negedge clk);
        mmu_output_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_m !== '0) begin
            n_err++;
            $display("FAIL mid_late_output: got rv=%b busy=%b m=%h expected rv=0000 busy=0 m=0", rsp_valid, busy, rsp_m);
        end
        req_valid = 4'b1111;
        #1;
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL mid_ptr_cleared: got %b expected 0001", req_ready);
        end
        wait_start(ok);
        req_valid = 4'b0000;
        mmu_respond(tag(32'h4400));
        n_vec++;
        if (rsp_valid !== 4'b0001 || rsp_m !== tag(32'h4400)) begin
            n_err++;
            $display("FAIL mid_after_rsp: got rv=%b m=%h expected rv=0001", rsp_valid, rsp_m);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = '0;
        mmu_sink_ready = 1'b0;
        mmu_output_valid = 1'b0;
        mmu_m = '0;
        test_reset();
        test_single_job();
        test_round_robin();
        test_wrap();
        test_sink_stall();
        test_timeout();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
